// File: rtl/div_issue_ctrl_pkg.sv
// Shared encodings and widths for the DIV/DIVU issue sequencer.
package div_issue_ctrl_pkg;

  localparam int REG_W  = 32;
  localparam int DREG_W = 64;

  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP  = 1'b0;

  localparam logic [REG_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    DIV_CTL_IDLE  = 2'b00,
    DIV_CTL_BUSY  = 2'b01,
    DIV_CTL_DONE  = 2'b10,
    DIV_CTL_ABORT = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_issue_ctrl.sv
// EX-stage sequencer for DIV/DIVU: holds operands for the iterative divider,
// stalls the pipe while it runs, and turns its result into a one-cycle HI/LO write.
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_div_op_i,
  input  logic              ex_signed_i,
  input  logic [REG_W-1:0]  ex_op1_i,
  input  logic [REG_W-1:0]  ex_op2_i,
  input  logic              flush_i,
  output logic              div_start_o,
  output logic              div_annul_o,
  output logic              div_signed_o,
  output logic [REG_W-1:0]  div_op1_o,
  output logic [REG_W-1:0]  div_op2_o,
  input  logic [DREG_W-1:0] div_result_i,
  input  logic              div_ready_i,
  output logic              stall_req_o,
  output logic              hilo_we_o,
  output logic [REG_W-1:0]  hi_o,
  output logic [REG_W-1:0]  lo_o
);

  div_state_e state;

  // Sequencer FSM; operand and result registers are owned here so they only
  // move on issue/completion and stay frozen while the divider re-reads them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= DIV_CTL_IDLE;
      div_start_o  <= DIV_STOP;
      div_signed_o <= 1'b0;
      div_op1_o    <= ZERO_WORD;
      div_op2_o    <= ZERO_WORD;
      hi_o         <= ZERO_WORD;
      lo_o         <= ZERO_WORD;
    end else begin
      case (state)
        DIV_CTL_IDLE: begin
          if (ex_div_op_i && !flush_i) begin
            div_op1_o    <= ex_op1_i;
            div_op2_o    <= ex_op2_i;
            div_signed_o <= ex_signed_i;
            div_start_o  <= DIV_START;
            state        <= DIV_CTL_BUSY;
          end
        end
        DIV_CTL_BUSY: begin
          // A flush wins over a simultaneous ready: the result is discarded.
          if (flush_i) begin
            div_start_o <= DIV_STOP;
            state       <= DIV_CTL_ABORT;
          end else if (div_ready_i) begin
            hi_o        <= div_result_i[DREG_W-1:REG_W];
            lo_o        <= div_result_i[REG_W-1:0];
            div_start_o <= DIV_STOP;
            state       <= DIV_CTL_DONE;
          end
        end
        // DONE ignores ex_div_op_i: the finished instruction is still in EX.
        DIV_CTL_DONE:  state <= DIV_CTL_IDLE;
        DIV_CTL_ABORT: state <= DIV_CTL_IDLE;
        default:       state <= DIV_CTL_IDLE;
      endcase
    end
  end

  // Stall covers the issue cycle (operands still being latched) and all of BUSY.
  assign stall_req_o = ((state == DIV_CTL_IDLE) && ex_div_op_i && !flush_i) ||
                       (state == DIV_CTL_BUSY);

  // Annul follows flush immediately and is held for the ABORT cycle.
  assign div_annul_o = flush_i || (state == DIV_CTL_ABORT);

  // HI/LO write in DONE unless a late flush kills the instruction.
  assign hilo_we_o   = (state == DIV_CTL_DONE) && !flush_i;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural iterative-divider model.
module tb_div_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_div_op, ex_signed, flush;
  logic [31:0] ex_op1, ex_op2;
  logic        div_start, div_annul, div_signed;
  logic [31:0] div_op1, div_op2;
  logic [63:0] div_result;
  logic        div_ready;
  logic        stall_req, hilo_we;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_issue_ctrl dut (
    .clk(clk), .reset(reset), .ex_div_op_i(ex_div_op), .ex_signed_i(ex_signed),
    .ex_op1_i(ex_op1), .ex_op2_i(ex_op2), .flush_i(flush),
    .div_start_o(div_start), .div_annul_o(div_annul), .div_signed_o(div_signed),
    .div_op1_o(div_op1), .div_op2_o(div_op2), .div_result_i(div_result),
    .div_ready_i(div_ready), .stall_req_o(stall_req), .hilo_we_o(hilo_we),
    .hi_o(hi), .lo_o(lo)
  );

  // Divider model: 33 cycles to ready for nonzero divisor, 3 for zero; ready
  // is held until start drops, result is {remainder, quotient}.
  logic [5:0] dcnt;
  function automatic logic [63:0] div_calc(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a; sb = b;
    if (b == 32'd0) return 64'd0;
    if (s) return {32'(sa % sb), 32'(sa / sb)};
    return {a % b, a / b};
  endfunction

  always @(posedge clk) begin
    if (reset || div_start !== 1'b1 || div_annul) begin
      dcnt      <= '0;
      div_ready <= 1'b0;
    end else if (dcnt == ((div_op2 == 32'd0) ? 6'd3 : 6'd33)) begin
      div_ready  <= 1'b1;
      div_result <= div_calc(div_signed, div_op1, div_op2);
    end else begin
      dcnt <= dcnt + 6'd1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one divide at a negedge and watch it to completion. With chain set,
  // ex_div_op stays high with the old operands through DONE and the task
  // returns at the next negedge so the caller can issue back-to-back.
  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input bit chain, output int stalls, output int pulses,
                         output logic [31:0] rhi, output logic [31:0] rlo,
                         output int opbad, output bit timeout);
    int tail;
    ex_signed = s; ex_op1 = a; ex_op2 = b; ex_div_op = 1'b1;
    stalls = 0; pulses = 0; opbad = 0; timeout = 1'b1; tail = -1;
    rhi = 'x; rlo = 'x;
    for (int i = 0; i < 120; i++) begin
      #1;
      if (stall_req) stalls++;
      if (div_start && (div_op1 !== a || div_op2 !== b || div_signed !== s)) opbad++;
      if (hilo_we) begin
        pulses++; rhi = hi; rlo = lo; timeout = 1'b0;
        if (!chain) ex_div_op = 1'b0;
        tail = chain ? 0 : 3;
      end
      @(negedge clk);
      if (tail == 0) break;
      if (tail > 0) tail--;
    end
  endtask

  int st, pu, ob;
  logic [31:0] rh, rl;
  bit to;

  initial begin
    reset = 1'b1; ex_div_op = 1'b0; ex_signed = 1'b0; flush = 1'b0;
    ex_op1 = '0; ex_op2 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_start", div_start, 0);
    chk("rst_signed", div_signed, 0);
    chk("rst_op1", div_op1, 0);
    chk("rst_op2", div_op2, 0);
    chk("rst_hilo", {hi, lo}, 0);
    chk("rst_we", hilo_we, 0);
    chk("rst_stall", stall_req, 0);
    @(negedge clk);

    // DIVU 100/7
    run_div(1'b0, 32'd100, 32'd7, 1'b0, st, pu, rh, rl, ob, to);
    chk("divu_timeout", to, 0);
    chk("divu_stall", st, 36);
    chk("divu_pulses", pu, 1);
    chk("divu_lo", rl, 32'd14);
    chk("divu_hi", rh, 32'd2);
    chk("divu_opstable", ob, 0);

    // DIV -7/2
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, st, pu, rh, rl, ob, to);
    chk("div_timeout", to, 0);
    chk("div_lo", rl, 32'hFFFF_FFFD);
    chk("div_hi", rh, 32'hFFFF_FFFF);
    chk("div_opstable", ob, 0);
    chk("div_pulses", pu, 1);

    // DIV 5/0
    run_div(1'b1, 32'd5, 32'd0, 1'b0, st, pu, rh, rl, ob, to);
    chk("dz_timeout", to, 0);
    chk("dz_stall", st, 6);
    chk("dz_pulses", pu, 1);
    chk("dz_hilo", {rh, rl}, 0);

    // flush at cycle 10 of BUSY
    ex_signed = 1'b0; ex_op1 = 32'd100; ex_op2 = 32'd7; ex_div_op = 1'b1;
    @(negedge clk);
    repeat (9) @(negedge clk);
    flush = 1'b1; ex_div_op = 1'b0;
    #1;
    chk("fl_annul_busy", div_annul, 1);
    chk("fl_we_busy", hilo_we, 0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("fl_abort_annul", div_annul, 1);
    chk("fl_abort_start", div_start, 0);
    chk("fl_abort_stall", stall_req, 0);
    chk("fl_abort_we", hilo_we, 0);
    @(negedge clk);
    #1;
    chk("fl_idle_annul", div_annul, 0);
    pu = 0;
    for (int i = 0; i < 40; i++) begin
      if (hilo_we || div_start) pu++;
      @(negedge clk); #1;
    end
    chk("fl_no_write", pu, 0);
    @(negedge clk);

    // two DIVU back-to-back
    run_div(1'b0, 32'd9, 32'd3, 1'b1, st, pu, rh, rl, ob, to);
    chk("b2b1_timeout", to, 0);
    chk("b2b1_res", {rh, rl}, {32'd0, 32'd3});
    run_div(1'b0, 32'd8, 32'd3, 1'b0, st, pu, rh, rl, ob, to);
    chk("b2b2_timeout", to, 0);
    chk("b2b2_stall", st, 36);
    chk("b2b2_pulses", pu, 1);
    chk("b2b2_res", {rh, rl}, {32'd2, 32'd2});
    chk("b2b2_opstable", ob, 0);

    // reset at cycle 20 of BUSY
    ex_signed = 1'b1; ex_op1 = 32'd100; ex_op2 = 32'd7; ex_div_op = 1'b1;
    @(negedge clk);
    repeat (19) @(negedge clk);
    reset = 1'b1; ex_div_op = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mr_start", div_start, 0);
    chk("mr_signed", div_signed, 0);
    chk("mr_ops", {div_op1, div_op2}, 0);
    chk("mr_hilo", {hi, lo}, 0);
    chk("mr_stall", stall_req, 0);
    pu = 0;
    for (int i = 0; i < 40; i++) begin
      if (hilo_we) pu++;
      @(negedge clk); #1;
    end
    chk("mr_no_write", pu, 0);
    @(negedge clk);
    run_div(1'b0, 32'd9, 32'd3, 1'b0, st, pu, rh, rl, ob, to);
    chk("mr_new_timeout", to, 0);
    chk("mr_new_res", {rh, rl}, {32'd0, 32'd3});
    chk("mr_new_pulses", pu, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
